arm_controller: RTL
===================

ARM_CONTROLLER -- requirements
Module: arm_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: clk in 1 clock; reset in 1 sync active-high reset.
REQ-002 The block SHALL have these ports: Instr in 32 current instruction; ALUFlags in 4 {N,Z,C,V} from ALU; mem_ready in 1 data-memory ack.
REQ-003 The block SHALL have these outputs: RegSrc 2; RegWrite 1; ImmSrc 2; ALUSrc 1; ALUControl 4; MemToReg 1; PCSrc 1; MemWrite 1; mem_req 1 data-memory request; PCEn 1 PC advance enable; halted 1 sticky halt flag.

Function
REQ-004 Decode SHALL use Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12]; Op 00 data-processing (DP), 01 memory, 10 branch, 11 undefined.
REQ-005 ALUControl SHALL encode ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101; DP cmd Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (SUB, no write); other cmds treated as undefined.
REQ-006 Memory ops SHALL use ADD when Funct[3]=1, else SUB; branch SHALL use ADD.
REQ-007 Static decode SHALL be: ImmSrc DP 00/mem 01/br 10; ALUSrc = Funct[5] for DP, 1 otherwise; RegSrc[0]=1 only for branch; RegSrc[1]=1 only for STR; MemToReg=1 only for LDR.
REQ-008 FSM states SHALL be RUN, MEMWAIT, HALT; reset enters RUN.
REQ-009 In RUN, a DP or branch instruction SHALL complete in one cycle: PCEn=1, RegWrite/PCSrc asserted combinationally when condition passes.
REQ-010 In RUN, a passing LDR/STR SHALL assert mem_req=1, PCEn=0, RegWrite=0, MemWrite=0, and transition to MEMWAIT next edge.
REQ-011 In MEMWAIT, mem_req SHALL stay 1; while mem_ready=0, PCEn=0 and no writes; on mem_ready=1, STR asserts MemWrite=1, LDR asserts RegWrite=1, PCEn=1, and FSM returns to RUN next edge.
REQ-012 A memory instruction whose condition fails SHALL complete in one RUN cycle with mem_req=0 and PCEn=1.
REQ-013 Undefined op or cmd SHALL move to HALT next edge; HALT forces PCEn, RegWrite, MemWrite, mem_req, PCSrc to 0 and halted=1 until reset.
REQ-014 RegWrite SHALL be 0 for STR, CMP, branch and failed conditions; PCSrc SHALL be 1 for a taken branch or a committed register write with Rd=15.
REQ-015 A 4-bit flags register SHALL load ALUFlags at the edge a passing DP instruction with Funct[0]=1 (S) or CMP completes; otherwise hold.
REQ-016 Condition evaluation SHALL use the registered flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
REQ-017 Flags written by instruction k SHALL be visible to the condition of instruction k+1 (no bypass required; register update precedes next decode).

Reset
REQ-018 Reset SHALL override all inputs including mem_ready, also mid-MEMWAIT, and drop the pending access without MemWrite/RegWrite.
REQ-019 After reset: state RUN, flags 0000, halted 0, mem_req 0, MemWrite 0; other outputs follow combinational decode of Instr.

Configuration
REQ-020 Macro ARM_CTRL_COND_EXEC_EN SHALL, when defined, enable REQ-016 condition evaluation.
REQ-021 Without ARM_CTRL_COND_EXEC_EN, every instruction SHALL be treated as condition-passed (including Cond=1111); flags register still updates per REQ-015.

Verification
REQ-022 Reset, then ADD R1,R2,#5 (Instr 0xE2821005) -> RegWrite=1, ALUSrc=1, ALUControl=0000, PCEn=1, flags unchanged.
REQ-023 SUBS R0,R0,R0 with ALUFlags=0100 then BEQ (0x0A000002) -> flags=0100, PCSrc=1, RegSrc[0]=1; repeat with BNE (0x1A000002) -> PCSrc=0, PCEn=1.
REQ-024 LDR R3,[R4,#8] (0xE5943008), mem_ready low 3 cycles -> mem_req=1 4 cycles, PCEn=0 for 3, RegWrite=1/MemToReg=1/PCEn=1 in the ready cycle, then RUN.
REQ-025 STR (0xE5843000) with reset asserted in 2nd MEMWAIT cycle -> MemWrite never 1; state RUN, mem_req=0 next cycle.
REQ-026 Instr 0xEC000000 (Op=11) -> halted=1 next cycle, PCEn=0 forever until reset.
REQ-027 Cond=1111 DP instruction -> RegWrite=0 with ARM_CTRL_COND_EXEC_EN defined; RegWrite=1 without it.

Source files
------------

// File: rtl/arm_controller.sv
// Multi-cycle ARM-subset control unit: decode, condition check, memory handshake FSM, sticky halt.
// Define ARM_CTRL_COND_EXEC_EN to evaluate condition codes; otherwise every instruction is condition-passed.
module arm_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        MemToReg,
  output logic        PCSrc,
  output logic        MemWrite,
  output logic        mem_req,
  output logic        PCEn,
  output logic        halted
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_HALT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;

  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_cmd;
  logic        w_rd_pc;
  logic        w_is_dp;
  logic        w_is_mem;
  logic        w_is_br;
  logic        w_is_ldr;
  logic        w_is_str;
  logic        w_is_cmp;
  logic        w_dp_ok;
  logic [3:0]  w_dp_alu;
  logic        w_undef;
  logic        w_cond_pass;
  logic        w_flag_we;
  logic        w_unused_bits;

  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_cmd    = w_funct[4:1];
  assign w_rd_pc  = (Instr[15:12] == 4'hF);
  assign w_is_dp  = (w_op == 2'b00);
  assign w_is_mem = (w_op == 2'b01);
  assign w_is_br  = (w_op == 2'b10);
  assign w_is_ldr = w_is_mem & w_funct[0];
  assign w_is_str = w_is_mem & ~w_funct[0];
  assign w_is_cmp = w_is_dp & (w_cmd == 4'b1010);
  assign w_undef  = (w_op == 2'b11) | (w_is_dp & ~w_dp_ok);
  assign w_unused_bits = ^{Instr[19:16], Instr[11:0]};

  always_comb begin
    w_dp_ok  = 1'b1;
    w_dp_alu = ALU_ADD;
    case (w_cmd)
      4'b0100: w_dp_alu = ALU_ADD;
      4'b0010: w_dp_alu = ALU_SUB;
      4'b0000: w_dp_alu = ALU_AND;
      4'b1100: w_dp_alu = ALU_ORR;
      4'b0001: w_dp_alu = ALU_EOR;
      4'b1101: w_dp_alu = ALU_MOV;
      4'b1010: w_dp_alu = ALU_SUB;
      default: w_dp_ok  = 1'b0;
    endcase
  end

`ifdef ARM_CTRL_COND_EXEC_EN
  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_pass = 1'b0;
    case (Instr[31:28])
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = ~w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = ~w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = ~w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = ~w_v;
      4'b1000: w_cond_pass = w_c & ~w_z;
      4'b1001: w_cond_pass = ~w_c | w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
      4'b1101: w_cond_pass = w_z | (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end
`else
  logic w_unused_cond;
  assign w_unused_cond = ^Instr[31:28];
  assign w_cond_pass   = 1'b1;
`endif

  // Static decode depends only on Instr, independent of FSM state.
  always_comb begin
    RegSrc   = {w_is_str, w_is_br};
    MemToReg = w_is_ldr;
    ImmSrc   = w_is_mem ? 2'b01 : (w_is_br ? 2'b10 : 2'b00);
    ALUSrc   = w_is_dp ? w_funct[5] : 1'b1;
    if (w_is_dp)       ALUControl = w_dp_alu;
    else if (w_is_mem) ALUControl = w_funct[3] ? ALU_ADD : ALU_SUB;
    else               ALUControl = ALU_ADD;
  end

  always_comb begin
    w_next    = r_state;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    mem_req   = 1'b0;
    PCEn      = 1'b0;
    PCSrc     = 1'b0;
    w_flag_we = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_undef) begin
          w_next = S_HALT;
        end else if (w_is_mem) begin
          if (w_cond_pass) begin
            mem_req = 1'b1;
            w_next  = S_MEMWAIT;
          end else begin
            PCEn = 1'b1;
          end
        end else begin
          PCEn = 1'b1;
          if (w_cond_pass) begin
            if (w_is_br) begin
              PCSrc = 1'b1;
            end else begin
              RegWrite  = ~w_is_cmp;
              PCSrc     = ~w_is_cmp & w_rd_pc;
              w_flag_we = w_funct[0] | w_is_cmp;
            end
          end
        end
      end
      S_MEMWAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          PCEn     = 1'b1;
          MemWrite = w_is_str;
          RegWrite = w_is_ldr;
          PCSrc    = w_is_ldr & w_rd_pc;
          w_next   = S_RUN;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RUN;
    endcase
    // Reset wins over mem_ready: a pending access is abandoned with no side effects.
    if (reset) begin
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      mem_req   = 1'b0;
      PCEn      = 1'b0;
      PCSrc     = 1'b0;
      w_flag_we = 1'b0;
      w_next    = S_RUN;
    end
  end

  assign halted = (r_state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (w_flag_we) r_flags <= ALUFlags;
    end
  end

endmodule
